wshb_arbiter: RTL
=================

// Module: wshb_arbiter
// PURPOSE
//  Round-robin Wishbone B4 classic arbiter sharing one SDRAM slave port between
//  two masters: M0 = VGA frame reader (display refill), M1 = frame writer.
//  Bounds each tenure by a beat quota so the display reader cannot starve.
//  Sits between both masters and the SDRAM controller on the system clock.
// PARAMETERS
//  AW         32  address width, bytes
//  DW         32  data width; SEL width = DW/8
//  MAX_BEATS  64  acks per tenure before forced hand-over; 0 = unlimited
// PORTS
//  clk          in   1      system/Wishbone clock
//  rst_n        in   1      synchronous reset, active low
//  m0_cyc/m1_cyc  in  1     master cycle request
//  m0_stb/m1_stb  in  1     master strobe
//  m0_we/m1_we    in  1     master write enable
//  m0_adr/m1_adr  in  AW    master address
//  m0_dat/m1_dat  in  DW    master write data
//  m0_sel/m1_sel  in  DW/8  master byte selects
//  m0_ack/m1_ack  out 1     ack routed to granted master only
//  m_dat_sm       out DW    slave read data, broadcast to both masters
//  s_cyc,s_stb,s_we out 1   to slave
//  s_adr          out AW    to slave
//  s_dat          out DW    to slave
//  s_sel          out DW/8  to slave
//  s_ack          in  1     slave ack
//  s_dat_sm       in  DW    slave read data
//  grant          out 2     one-hot current owner {M1,M0}; 00 = idle
// BEHAVIOUR
//  One clock (clk); reset synchronous, active low (rst_n).
//  Reset: state=IDLE, grant=00, last=1 (M0 wins first tie), beats=0;
//   s_cyc=s_stb=s_we=0, m0_ack=m1_ack=0. Reset mid-transfer aborts immediately.
//  FSM states IDLE, G0, G1 (registered); slave-side mux combinational from state.
//  IDLE: s_cyc=s_stb=0, all acks 0, s_ack ignored.
//   Only m0_cyc -> G0; only m1_cyc -> G1; both -> master != last; none -> IDLE.
//  Gx: s_* = mx_*; mx_ack = s_ack; other master's ack = 0.
//   On entry beats=0, last<=x. Each cycle with s_ack: beats += 1.
//  Release Gx -> IDLE next edge when:
//   (a) mx_cyc=0; or
//   (b) MAX_BEATS!=0, s_ack=1, beats==MAX_BEATS-1, and the other master's cyc=1.
//   Case (b) applies even though mx_cyc stays high; mx stalls (ack=0) until
//   re-granted, which is legal classic-cycle waiting.
//  Every change of owner passes through IDLE for exactly one cycle (dead cycle).
//  Request seen in cycle N at IDLE -> s_stb visible in N+1. First ack no earlier than N+1.
//  Quota reached with no competing request: keep grant, beats saturates at
//   MAX_BEATS-1 (no wrap).
//  mx_cyc dropping in the same cycle as s_ack: ack delivered, then IDLE.
//  Arbiter never asserts s_stb without the owner's stb. s_we/s_adr/s_sel pass unmodified.
//  beats width = $clog2(MAX_BEATS+1); MAX_BEATS=0 disables the counter.
// TESTING
//  1 Hold rst_n=0 with both cyc=1 -> grant=00, s_cyc=0, acks 0; release -> grant=01.
//  2 Only M1 reads adr 0x100, slave acks after 2 wait states -> m1_ack once,
//    m_dat_sm=slave data, m0_ack=0, grant 10->00 after m1_cyc drops.
//  3 Both cyc rise same cycle, single-beat cycles -> grants 01,00,10,00,01 (alternation).
//  4 MAX_BEATS=4; M0 streams with cyc held, M1 requests -> exactly 4 m0_acks,
//    IDLE 1 cycle, M1 served, then M0 resumes at its unacked adr.
//  5 MAX_BEATS=4; M0 streams alone for 10 beats -> no release, 10 acks, beats=3.
//  6 rst_n=0 during a G1 wait state -> next edge s_cyc=0, grant=00, m1_ack never pulses.

Source files
------------

// File: rtl/wshb_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: two masters share one SDRAM slave
// port. M0 is the display refill reader, M1 the frame writer. Each tenure is
// bounded by a beat quota so that neither master can starve the other.
//
// Handshake: the slave-side signals follow the granted master combinationally.
// A beat completes on a cycle where the owner holds cyc&stb and the slave
// returns s_ack. Only the owner ever sees ack. A master that loses the grant
// mid-cycle simply sees no ack until it is granted again, which is ordinary
// classic-cycle waiting.
module wshb_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BEATS = 64,
    localparam int BW       = (MAX_BEATS == 0) ? 1 : $clog2(MAX_BEATS + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_cyc,
    input  logic            m0_stb,
    input  logic            m0_we,
    input  logic [AW-1:0]   m0_adr,
    input  logic [DW-1:0]   m0_dat,
    input  logic [DW/8-1:0] m0_sel,
    output logic            m0_ack,
    input  logic            m1_cyc,
    input  logic            m1_stb,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_adr,
    input  logic [DW-1:0]   m1_dat,
    input  logic [DW/8-1:0] m1_sel,
    output logic            m1_ack,
    output logic [DW-1:0]   m_dat_sm,
    output logic            s_cyc,
    output logic            s_stb,
    output logic            s_we,
    output logic [AW-1:0]   s_adr,
    output logic [DW-1:0]   s_dat,
    output logic [DW/8-1:0] s_sel,
    input  logic            s_ack,
    input  logic [DW-1:0]   s_dat_sm,
    output logic [1:0]      grant,
    output logic [1:0]      dbg_state,
    output logic [BW-1:0]   dbg_beats
);

    // State encoding doubles as the one-hot grant vector {M1,M0}.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } state_t;

    // Beat index at which the quota is reached (unused when MAX_BEATS is 0).
    localparam logic [BW-1:0] QUOTA_LAST = (MAX_BEATS == 0) ? '0 : BW'(MAX_BEATS - 1);
    localparam bit            QUOTA_ON   = (MAX_BEATS != 0);

    state_t        r_state;
    state_t        w_next;
    logic          r_last;      // 0: M0 owned last, 1: M1 owned last
    logic [BW-1:0] r_beats;
    logic          w_quota_hit;

    // Last beat of the quota is being acked in this cycle.
    assign w_quota_hit = QUOTA_ON && s_ack && (r_beats == QUOTA_LAST);

    // State register; reset aborts any tenure immediately.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Round-robin history and per-tenure beat counter (saturating).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last  <= 1'b1;
            r_beats <= '0;
        end else if (r_state == ST_IDLE) begin
            r_beats <= '0;
            if (w_next == ST_G0) begin
                r_last <= 1'b0;
            end else if (w_next == ST_G1) begin
                r_last <= 1'b1;
            end
        end else if (QUOTA_ON && s_ack && (r_beats != QUOTA_LAST)) begin
            r_beats <= r_beats + BW'(1);
        end
    end

    // Next-state: every change of owner passes through IDLE for one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    w_next = r_last ? ST_G0 : ST_G1;
                end else if (m0_cyc) begin
                    w_next = ST_G0;
                end else if (m1_cyc) begin
                    w_next = ST_G1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_G0: begin
                if (!m0_cyc || (w_quota_hit && m1_cyc)) begin
                    w_next = ST_IDLE;
                end
            end
            ST_G1: begin
                if (!m1_cyc || (w_quota_hit && m0_cyc)) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Output mux: slave side follows the owner, ack goes to the owner only.
    always_comb begin
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        s_we   = 1'b0;
        s_adr  = '0;
        s_dat  = '0;
        s_sel  = '0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        case (r_state)
            ST_G0: begin
                s_cyc  = m0_cyc;
                s_stb  = m0_stb;
                s_we   = m0_we;
                s_adr  = m0_adr;
                s_dat  = m0_dat;
                s_sel  = m0_sel;
                m0_ack = s_ack;
            end
            ST_G1: begin
                s_cyc  = m1_cyc;
                s_stb  = m1_stb;
                s_we   = m1_we;
                s_adr  = m1_adr;
                s_dat  = m1_dat;
                s_sel  = m1_sel;
                m1_ack = s_ack;
            end
            default: begin
                s_cyc  = 1'b0;
                s_stb  = 1'b0;
            end
        endcase
    end

    assign m_dat_sm  = s_dat_sm;
    assign grant     = r_state;
    assign dbg_state = r_state;
    assign dbg_beats = r_beats;

endmodule
